// File: rtl/kmeans_ctrl_pkg.sv
// Shared types and sizing helpers for the k-means k2n5 iteration controller.
package kmeans_ctrl_pkg;

   localparam int K = 2;
   localparam int D = 5;

   typedef enum logic [2:0] {
      IDLE,
      STREAM,
      DRAIN,
      DIVIDE,
      UPDATE,
      FINISH
   } ctrl_state_t;

   // A full pass of maximal values cannot overflow a sum this wide.
   function automatic int sumWidth(input int dataWidth, input int qtyBitWidth);
      return dataWidth + qtyBitWidth;
   endfunction

   function automatic int countWidth(input int qtyBitWidth);
      return qtyBitWidth + 1;
   endfunction

endpackage

// File: rtl/kmeans_divider.sv
// Unsigned restoring divider, one quotient bit per cycle; o_done pulses
// DIVIDEND_W cycles after i_start. Synchronous active-low reset aborts it.
module kmeans_divider #(
   parameter int DIVIDEND_W = 16,
   parameter int DIVISOR_W  = 9,
   parameter int QUOT_W     = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_start,
   input  logic [DIVIDEND_W-1:0] i_dividend,
   input  logic [DIVISOR_W-1:0]  i_divisor,
   output logic [QUOT_W-1:0]     o_quotient,
   output logic                  o_done
);

   localparam int CNT_W = $clog2(DIVIDEND_W + 1);

   logic [DIVISOR_W-1:0]  r_rem;
   logic [DIVISOR_W-1:0]  r_divisor;
   logic [DIVIDEND_W-1:0] r_quo;
   logic [CNT_W-1:0]      r_cnt;
   logic                  r_busy;
   logic                  r_done;

   logic [DIVISOR_W-1:0]  w_remIn;
   logic [DIVIDEND_W-1:0] w_quoIn;
   logic [DIVISOR_W-1:0]  w_dvs;
   logic [DIVISOR_W:0]    w_shift;
   logic                  w_fits;
   logic [DIVISOR_W-1:0]  w_remNext;
   logic [DIVIDEND_W-1:0] w_quoNext;

   // The start cycle already performs the first step on the fresh operands.
   always_comb begin
      w_remIn   = i_start ? '0 : r_rem;
      w_quoIn   = i_start ? i_dividend : r_quo;
      w_dvs     = i_start ? i_divisor : r_divisor;
      w_shift   = {w_remIn, w_quoIn[DIVIDEND_W-1]};
      w_fits    = (w_shift >= {1'b0, w_dvs});
      w_remNext = w_fits ? DIVISOR_W'(w_shift - {1'b0, w_dvs}) : w_shift[DIVISOR_W-1:0];
      w_quoNext = {w_quoIn[DIVIDEND_W-2:0], w_fits};
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_rem     <= '0;
         r_quo     <= '0;
         r_divisor <= '0;
         r_cnt     <= '0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (i_start || r_busy) begin
            r_rem <= w_remNext;
            r_quo <= w_quoNext;
         end
         if (i_start) begin
            r_divisor <= i_divisor;
            r_cnt     <= CNT_W'(DIVIDEND_W - 1);
            r_busy    <= (DIVIDEND_W > 1);
            r_done    <= (DIVIDEND_W == 1);
         end else if (r_busy) begin
            r_cnt <= r_cnt - CNT_W'(1);
            if (r_cnt == CNT_W'(1)) begin
               r_busy <= 1'b0;
               r_done <= 1'b1;
            end
         end
      end
   end

   assign o_quotient = r_quo[QUOT_W-1:0];
   assign o_done     = r_done;

endmodule

// File: rtl/kmeans_k2n5_controller.sv
// Iteration controller for the 2-centroid, 5-dimension k-means datapath.
// Define KMEANS_CTRL_CONV_EN to also stop early once the centroids stop moving.
module kmeans_k2n5_controller
   import kmeans_ctrl_pkg::*;
#(
   parameter int input_data_width         = 8,
   parameter int input_data_qty_bit_width = 8,
   parameter int input_data_qty           = 256,
   parameter int pipe_latency             = 6,
   parameter int max_iter                 = 16,
   parameter int k0_d0_initial            = 0,
   parameter int k0_d1_initial            = 0,
   parameter int k0_d2_initial            = 0,
   parameter int k0_d3_initial            = 0,
   parameter int k0_d4_initial            = 0,
   parameter int k1_d0_initial            = 1,
   parameter int k1_d1_initial            = 1,
   parameter int k1_d2_initial            = 1,
   parameter int k1_d3_initial            = 1,
   parameter int k1_d4_initial            = 1
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                start,
   output logic [input_data_qty_bit_width-1:0] rd_address,
   input  logic [5*input_data_width-1:0]       pt_data,
   input  logic                                sel_centroid,
   output logic [10*input_data_width-1:0]      centroids,
   output logic                                busy,
   output logic                                done,
   output logic [7:0]                          iterations
);

   localparam int DW    = input_data_width;
   localparam int QB    = input_data_qty_bit_width;
   localparam int SUM_W = sumWidth(input_data_width, input_data_qty_bit_width);
   localparam int CNT_W = countWidth(input_data_qty_bit_width);
   localparam int LAT_W = $clog2(pipe_latency + 1);
   localparam int KI_W  = $clog2(K);
   localparam int DI_W  = $clog2(D);
   localparam logic [QB-1:0] LAST_ADDR = QB'(input_data_qty - 1);

   localparam logic [K-1:0][D-1:0][DW-1:0] INIT_CENT = {
      DW'(k1_d4_initial), DW'(k1_d3_initial), DW'(k1_d2_initial), DW'(k1_d1_initial), DW'(k1_d0_initial),
      DW'(k0_d4_initial), DW'(k0_d3_initial), DW'(k0_d2_initial), DW'(k0_d1_initial), DW'(k0_d0_initial)};

   ctrl_state_t                     r_state;
   logic [QB-1:0]                   r_addr;
   logic [pipe_latency-1:0]         r_valid;
   logic [LAT_W-1:0]                r_drainCnt;
   logic [K-1:0][D-1:0][SUM_W-1:0]  r_sum;
   logic [K-1:0][CNT_W-1:0]         r_count;
   logic [K-1:0][D-1:0][DW-1:0]     r_cent;
   logic [K-1:0][D-1:0][DW-1:0]     r_new;
   logic [KI_W-1:0]                 r_divK;
   logic [DI_W-1:0]                 r_divD;
   logic                            r_divWait;
   logic [7:0]                      r_iter;
   logic                            r_busy;
   logic                            r_done;

   logic                            w_issue;
   logic                            w_clearAcc;
   logic                            w_emptyCluster;
   logic                            w_divStart;
   logic                            w_divDone;
   logic                            w_elemDone;
   logic [DW-1:0]                   w_quotient;
   logic [7:0]                      w_iterNext;
   logic                            w_exit;

   always_comb begin
      w_iterNext     = r_iter + 8'd1;
      w_issue        = (r_state == STREAM);
      w_emptyCluster = (r_count[r_divK] == '0);
      w_divStart     = (r_state == DIVIDE) && !w_emptyCluster && !r_divWait;
      w_elemDone     = (r_state == DIVIDE) && (w_emptyCluster || (r_divWait && w_divDone));
`ifdef KMEANS_CTRL_CONV_EN
      w_exit         = (w_iterNext >= 8'(max_iter)) || (r_new == r_cent);
`else
      w_exit         = (w_iterNext >= 8'(max_iter));
`endif
      w_clearAcc     = ((r_state == IDLE) && start) || ((r_state == UPDATE) && !w_exit);
   end

   kmeans_divider #(
      .DIVIDEND_W (SUM_W),
      .DIVISOR_W  (CNT_W),
      .QUOT_W     (DW)
   ) u_divider (
      .clk        (clk),
      .rst        (rst),
      .i_start    (w_divStart),
      .i_dividend (r_sum[r_divK][r_divD]),
      .i_divisor  (r_count[r_divK]),
      .o_quotient (w_quotient),
      .o_done     (w_divDone)
   );

   // The valid shift register mirrors the pipeline so sums only see real points.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_valid <= '0;
         r_sum   <= '0;
         r_count <= '0;
      end else begin
         r_valid[0] <= w_issue;
         for (int i = 1; i < pipe_latency; i++) begin
            r_valid[i] <= r_valid[i-1];
         end
         if (w_clearAcc) begin
            r_sum   <= '0;
            r_count <= '0;
         end else if (r_valid[pipe_latency-1]) begin
            for (int d = 0; d < D; d++) begin
               r_sum[sel_centroid][d] <= r_sum[sel_centroid][d] + SUM_W'(pt_data[d*DW +: DW]);
            end
            r_count[sel_centroid] <= r_count[sel_centroid] + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state    <= IDLE;
         r_addr     <= '0;
         r_drainCnt <= '0;
         r_cent     <= INIT_CENT;
         r_new      <= '0;
         r_divK     <= '0;
         r_divD     <= '0;
         r_divWait  <= 1'b0;
         r_iter     <= '0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_cent  <= INIT_CENT;
                  r_iter  <= '0;
                  r_addr  <= '0;
                  r_busy  <= 1'b1;
                  r_state <= STREAM;
               end
            end
            STREAM: begin
               if (r_addr == LAST_ADDR) begin
                  r_addr     <= '0;
                  r_drainCnt <= '0;
                  r_state    <= DRAIN;
               end else begin
                  r_addr <= r_addr + QB'(1);
               end
            end
            DRAIN: begin
               if (r_drainCnt == LAT_W'(pipe_latency - 1)) begin
                  r_divK    <= '0;
                  r_divD    <= '0;
                  r_divWait <= 1'b0;
                  r_state   <= DIVIDE;
               end else begin
                  r_drainCnt <= r_drainCnt + LAT_W'(1);
               end
            end
            // An empty cluster keeps its old centroid instead of dividing by zero.
            DIVIDE: begin
               if (w_divStart) begin
                  r_divWait <= 1'b1;
               end
               if (w_elemDone) begin
                  r_new[r_divK][r_divD] <= w_emptyCluster ? r_cent[r_divK][r_divD] : w_quotient;
                  r_divWait <= 1'b0;
                  if (r_divD == DI_W'(D - 1)) begin
                     r_divD <= '0;
                     if (r_divK == KI_W'(K - 1)) begin
                        r_state <= UPDATE;
                     end else begin
                        r_divK <= r_divK + KI_W'(1);
                     end
                  end else begin
                     r_divD <= r_divD + DI_W'(1);
                  end
               end
            end
            UPDATE: begin
               r_cent <= r_new;
               r_iter <= w_iterNext;
               if (w_exit) begin
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_state <= FINISH;
               end else begin
                  r_addr  <= '0;
                  r_state <= STREAM;
               end
            end
            FINISH: begin
               r_state <= IDLE;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign rd_address = r_addr;
   assign centroids  = r_cent;
   assign busy       = r_busy;
   assign done       = r_done;
   assign iterations = r_iter;

endmodule

// File: tb/tb_kmeans_k2n5_controller.sv
// Scoreboard bench for kmeans_k2n5_controller: a point RAM and a 6-cycle pipeline
// model feed the controller, and a monitor checks every done pulse against a queue.
module tb_kmeans_k2n5_controller;

   localparam int DW    = 8;
   localparam int QB    = 2;
   localparam int QTY   = 4;
   localparam int LAT   = 6;
   localparam int MAXIT = 3;
`ifdef KMEANS_CTRL_CONV_EN
   localparam logic [7:0] EXP_ITER = 8'd2;
`else
   localparam logic [7:0] EXP_ITER = 8'd3;
`endif

   typedef struct packed {
      logic [79:0] cent;
      logic [7:0]  iter;
   } expect_t;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              start = 1'b0;
   logic [QB-1:0]     rd_address;
   logic [5*DW-1:0]   pt_data;
   logic              sel_centroid;
   logic [10*DW-1:0]  centroids;
   logic              busy;
   logic              done;
   logic [7:0]        iterations;

   logic [DW-1:0]     ramBase [QTY];
   logic              selTab [QTY];
   logic [QB-1:0]     addrPipe [LAT];
   expect_t           expQ [$];
   int                testsRun = 0;
   int                failCount = 0;
   int                doneSeen = 0;

   always #5 clk = ~clk;

   kmeans_k2n5_controller #(
      .input_data_width         (DW),
      .input_data_qty_bit_width (QB),
      .input_data_qty           (QTY),
      .pipe_latency             (LAT),
      .max_iter                 (MAXIT),
      .k0_d0_initial (0),   .k0_d1_initial (0),   .k0_d2_initial (0),   .k0_d3_initial (0),   .k0_d4_initial (0),
      .k1_d0_initial (255), .k1_d1_initial (255), .k1_d2_initial (255), .k1_d3_initial (255), .k1_d4_initial (255)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .rd_address   (rd_address),
      .pt_data      (pt_data),
      .sel_centroid (sel_centroid),
      .centroids    (centroids),
      .busy         (busy),
      .done         (done),
      .iterations   (iterations)
   );

   // RAM read plus distance pipeline modelled as a pure address delay line.
   always @(posedge clk) begin
      addrPipe[0] <= rd_address;
      for (int i = 1; i < LAT; i++) begin
         addrPipe[i] <= addrPipe[i-1];
      end
   end

   always_comb begin
      pt_data = '0;
      for (int d = 0; d < 5; d++) begin
         pt_data[d*DW +: DW] = ramBase[addrPipe[LAT-1]] + DW'(d);
      end
      sel_centroid = selTab[addrPipe[LAT-1]];
   end

   function automatic logic [79:0] centVec(input logic [7:0] k0Mean, input logic [7:0] k0Step,
                                           input logic [7:0] k1Mean, input logic [7:0] k1Step);
      logic [79:0] v;
      v = '0;
      for (int d = 0; d < 5; d++) begin
         v[d*8 +: 8]      = k0Mean + k0Step * 8'(d);
         v[40 + d*8 +: 8] = k1Mean + k1Step * 8'(d);
      end
      return v;
   endfunction

   task automatic checkOutput(input string name, input logic [79:0] actual, input logic [79:0] expected);
      testsRun++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   task automatic checkReset(input string tag);
      checkOutput({tag, "_centroids"}, centroids, centVec(8'd0, 8'd0, 8'd255, 8'd0));
      checkOutput({tag, "_busy"}, 80'(busy), 80'(0));
      checkOutput({tag, "_done"}, 80'(done), 80'(0));
      checkOutput({tag, "_rdAddress"}, 80'(rd_address), 80'(0));
      checkOutput({tag, "_iterations"}, 80'(iterations), 80'(0));
   endtask

   task automatic loadPoints(input logic [7:0] p0, input logic [7:0] p1, input logic [7:0] p2, input logic [7:0] p3,
                             input logic s0, input logic s1, input logic s2, input logic s3);
      ramBase[0] = p0; ramBase[1] = p1; ramBase[2] = p2; ramBase[3] = p3;
      selTab[0] = s0;  selTab[1] = s1;  selTab[2] = s2;  selTab[3] = s3;
   endtask

   task automatic pulseStart();
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
   endtask

   task automatic waitDone(input int target);
      int cycles;
      cycles = 0;
      while (doneSeen < target && cycles < 3000) begin
         @(posedge clk);
         cycles++;
      end
      if (doneSeen < target) begin
         testsRun++;
         failCount++;
         $display("[TB] FAIL runTimeout: done count %0d, expected %0d", doneSeen, target);
         expQ.delete();
         doneSeen = target;
      end
   endtask

   // One full clustering run with hand-computed final centroids.
   task automatic applyStimulus(input logic [7:0] k0Mean, input logic [7:0] k0Step,
                                input logic [7:0] k1Mean, input logic [7:0] k1Step,
                                input bit midStart, input int target);
      expect_t e;
      e.cent = centVec(k0Mean, k0Step, k1Mean, k1Step);
      e.iter = EXP_ITER;
      expQ.push_back(e);
      pulseStart();
      checkOutput("busyAfterStart", 80'(busy), 80'(1));
      checkOutput("addrAfterStart", 80'(rd_address), 80'(0));
      if (midStart) begin
         @(posedge clk); #1;
         checkOutput("addrSecond", 80'(rd_address), 80'(1));
         start = 1'b1;
         @(posedge clk); #1 start = 1'b0;
      end
      waitDone(target);
   endtask

   initial begin : monitor
      expect_t e;
      forever begin
         @(negedge clk);
         if (done === 1'b1) begin
            if (expQ.size() == 0) begin
               testsRun++;
               failCount++;
               $display("[TB] FAIL unexpectedDone: done=1 with empty scoreboard");
            end else begin
               e = expQ.pop_front();
               checkOutput("centroids", centroids, e.cent);
               checkOutput("iterations", 80'(iterations), 80'(e.iter));
               checkOutput("busyAtDone", 80'(busy), 80'(0));
            end
            doneSeen++;
         end
      end
   end

   initial begin
      loadPoints(8'd0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      repeat (20) @(posedge clk);
      #1;
      checkReset("idle");

      // Two well separated clusters; per-dimension offset d rides on each point.
      loadPoints(8'd2, 8'd4, 8'd200, 8'd202, 1'b0, 1'b0, 1'b1, 1'b1);
      applyStimulus(8'd3, 8'd1, 8'd201, 8'd1, 1'b0, 1);

      // Everything to k0: k1 is empty and keeps its initial value.
      loadPoints(8'd2, 8'd4, 8'd200, 8'd202, 1'b0, 1'b0, 1'b0, 1'b0);
      applyStimulus(8'd102, 8'd1, 8'd255, 8'd0, 1'b0, 2);

      // Everything to k1: k0 is empty and stays at zero.
      loadPoints(8'd2, 8'd4, 8'd200, 8'd202, 1'b1, 1'b1, 1'b1, 1'b1);
      applyStimulus(8'd0, 8'd0, 8'd102, 8'd1, 1'b0, 3);

      // Odd sums truncate: (3+2d)/2 = 1+d, (201+2d)/2 = 100+d.
      loadPoints(8'd1, 8'd2, 8'd100, 8'd101, 1'b0, 1'b0, 1'b1, 1'b1);
      applyStimulus(8'd1, 8'd1, 8'd100, 8'd1, 1'b0, 4);

      // A second start during STREAM must not disturb the run.
      loadPoints(8'd2, 8'd4, 8'd200, 8'd202, 1'b0, 1'b0, 1'b1, 1'b1);
      applyStimulus(8'd3, 8'd1, 8'd201, 8'd1, 1'b1, 5);

      repeat (5) @(posedge clk);
      #1;
      checkOutput("holdCentroids", centroids, centVec(8'd3, 8'd1, 8'd201, 8'd1));
      checkOutput("holdIterations", 80'(iterations), 80'(EXP_ITER));
      checkOutput("holdBusy", 80'(busy), 80'(0));

      // Reset asserted in the middle of DRAIN aborts the run completely.
      loadPoints(8'd10, 8'd20, 8'd30, 8'd40, 1'b0, 1'b1, 1'b0, 1'b1);
      pulseStart();
      repeat (6) @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk); #1;
      checkReset("abort");
      rst = 1'b1;
      repeat (12) @(posedge clk);
      #1;
      checkOutput("abortNoDone", 80'(doneSeen), 80'(5));

      loadPoints(8'd2, 8'd4, 8'd200, 8'd202, 1'b0, 1'b0, 1'b1, 1'b1);
      applyStimulus(8'd3, 8'd1, 8'd201, 8'd1, 1'b0, 6);

      repeat (3) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
      $finish;
   end

endmodule
